// File: rtl/digit_serial_pkg.sv
// Shared definitions for the digit-serial adder.
//   DIGIT_W : bits handled per RUN cycle
//   state_e : controller states (IDLE, RUN, DONE)
package digit_serial_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_serial_adder_if.sv
// Handshake/data bundle between an operand producer/result consumer and the
// digit-serial adder.
//   in_valid/in_ready   : operand-set handshake (op_a, op_b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   master modport      : producer/consumer side
//   slave modport       : adder side
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/add2_cell.sv
// Combinational 2-bit ripple full-add cell.
//   cin : carry in
//   a,b : 2-bit digits
//   s   : 2-bit digit sum
//   co  : carry out of the digit
module add2_cell
  import digit_serial_pkg::*;
(
  input  logic               cin,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic c1;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign co   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, one 2-bit
// digit per clock, LSB digit first, through a single add2_cell.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of digit_serial_adder_if (operand and result handshakes)
// Result appears WIDTH/2 cycles after acceptance and is held until taken.
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  digit_serial_adder_if.slave  bus
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_co;
  logic               accept;

  // A new operand set may enter from IDLE, or from DONE in the same cycle the
  // consumer takes the previous result.
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  // Select the operand digits addressed by the digit counter.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        dig_a = a_q[k*DIGIT_W +: DIGIT_W];
        dig_b = b_q[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

  add2_cell u_cell (
    .cin (carry_q),
    .a   (dig_a),
    .b   (dig_b),
    .s   (dig_s),
    .co  (dig_co)
  );

  // Next-state and datapath updates. Acceptance overrides the DONE->IDLE
  // exit so a waiting operand set starts without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
      end
      RUN: begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            sum_d[k*DIGIT_W +: DIGIT_W] = dig_s;
          end
        end
        carry_d = dig_co;
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
          cout_d  = dig_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = bus.op_a;
      b_d     = bus.op_b;
      carry_d = bus.cin;
      sum_d   = '0;
      cout_d  = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are even and >= 2.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 SHALL have port op_a, input, WIDTH bits: addend A.
REQ-007 SHALL have port op_b, input, WIDTH bits: addend B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH bits: (op_a + op_b + cin) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry-out of the WIDTH-bit addition.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept an operand set when in_valid and in_ready are both 1 in the same cycle: op_a, op_b and cin are captured, digit counter cleared, FSM goes to RUN.
REQ-015 SHALL drive in_ready = 1 in IDLE, or in DONE when out_ready = 1; 0 otherwise.
REQ-016 SHALL process one 2-bit digit per RUN cycle, LSB digit first, using the 2-bit full-add cell.
- Cell inputs: carry register; A digit [2k+1:2k]; B digit [2k+1:2k].
- Cell outputs: 2 sum bits written to sum[2k+1:2k]; carry out written back to the carry register.
REQ-017 SHALL spend exactly WIDTH/2 cycles in RUN, then enter DONE; out_valid rises on the cycle after the last digit, i.e. WIDTH/2 cycles after acceptance.
REQ-018 SHALL hold out_valid = 1, sum and cout stable in DONE until out_ready = 1.
REQ-019 SHALL, in DONE with out_ready = 1, go to IDLE, or go directly to RUN if in_valid = 1 in that cycle (back-to-back, no bubble).
REQ-020 SHALL ignore in_valid while in RUN, or in DONE without out_ready.
REQ-021 SHALL keep sum and cout unchanged from DONE exit until the next acceptance; sum is cleared to 0 on acceptance.
REQ-022 SHALL use a digit counter of width clog2(WIDTH/2), minimum 1 bit; it shall not wrap within one operation.
REQ-023 SHALL produce cout equal to bit WIDTH of the full-precision sum; no overflow flag.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-RUN, abort the operation, go to IDLE, and clear the carry, counter, operand, sum and cout registers.
REQ-025 SHALL drive these output values during and after reset: in_ready = 1, out_valid = 0, sum = 0, cout = 0.
REQ-026 SHALL accept in_valid on the first clock edge after reset deasserts.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, RUN, DONE) and the DIGIT_W = 2 constant in a shared package, digit_serial_pkg.
REQ-028 SHALL instantiate one combinational sub-module add2_cell.
- Ports: cin, a[1:0], b[1:0], s[1:0], co.
- s[0] = a0^b0^cin.
- Internal carry c1 = majority(a0, b0, cin).
- s[1] = a1^b1^c1.
- co = majority(a1, b1, c1).
REQ-029 SHALL contain no other arithmetic: no WIDTH-wide adder.

Verification (WIDTH=16)
REQ-030 SHALL cover: op_a=0xFFFF, op_b=0x0001, cin=0 -> out_valid 8 cycles after acceptance, sum=0x0000, cout=1.
REQ-031 SHALL cover: op_a=0x1234, op_b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE, in_valid=1 throughout -> in_ready=0; sum/cout stable; new operands not captured.
REQ-033 SHALL cover: two operand sets, the second presented in the cycle DONE sees out_ready=1 -> second out_valid exactly 8 cycles later; first result = 0x8000+0x8000+0 -> sum=0x0000, cout=1.
REQ-034 SHALL cover: reset asserted during the 4th RUN cycle -> same cycle, out_valid=0, sum=0, in_ready=1; a following 0x0003+0x0005 gives 0x0008, cout=0.
REQ-035 SHALL cover: 10^4 random operands with random in_valid/out_ready gaps -> every result matches the reference model; no result dropped or duplicated.
